// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, schedule/round helper functions and
// the message-schedule state encoding. Used by the schedule unit and the round unit.
package sha256_pkg;

    localparam int ROUNDS = 64;

    typedef logic [31:0] word_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DELAY  = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_DELAY  = ST_DELAY,
        S_LOAD   = ST_LOAD,
        S_STREAM = ST_STREAM,
        S_DONE   = ST_DONE
    } sched_state_t;

    localparam word_t K [ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Message-schedule sigmas (lower-case in FIPS 180-4).
    function automatic word_t s0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t s1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Compression-round helpers, consumed by the round unit.
    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_krom.sv
// SHA-256 round-constant ROM: purely combinational lookup of K_t by round index.
module sha256_krom
    import sha256_pkg::*;
(
    input  logic [5:0]  addr,
    output logic [31:0] k
);

    assign k = K[addr];

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads a 16-word block after a programmable delay and streams
// W_0..W_63 on out0. Define SHA_KROM_EN to also drive the matching K_t on out1.
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int DELAY_W = 10,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4,
    input  logic [DATA_W-1:0] in5,
    input  logic [DATA_W-1:0] in6,
    input  logic [DATA_W-1:0] in7,
    input  logic [DATA_W-1:0] in8,
    input  logic [DATA_W-1:0] in9,
    input  logic [DATA_W-1:0] in10,
    input  logic [DATA_W-1:0] in11,
    input  logic [DATA_W-1:0] in12,
    input  logic [DATA_W-1:0] in13,
    input  logic [DATA_W-1:0] in14,
    input  logic [DATA_W-1:0] in15,
    input  logic [7:0]        delay0,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic              valid,
    output logic              done
);

    sched_state_t        state, state_nxt;
    logic [DELAY_W-1:0]  delay;
    logic [5:0]          t;
    logic [DATA_W-1:0]   window [16];
    logic [DATA_W-1:0]   in_w   [16];
    logic [DATA_W-1:0]   w_next;

    assign in_w = '{in0, in1, in2,  in3,  in4,  in5,  in6,  in7,
                    in8, in9, in10, in11, in12, in13, in14, in15};

    // Sliding 16-word window: window[0] is W_t, window[15] is W_{t+15}.
    assign w_next = s1(window[14]) + window[9] + s0(window[1]) + window[0];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        if (run) begin
            state_nxt = S_DELAY;
        end else begin
            case (state)
                S_DELAY:  if (delay == '0) state_nxt = S_LOAD;
                S_LOAD:   state_nxt = S_STREAM;
                S_STREAM: if (t == 6'(ROUNDS - 1)) state_nxt = S_DONE;
                default:  state_nxt = state;
            endcase
        end
    end

    // NOTE: the 16-word window is reset explicitly because out0 exposes window[0] from reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            delay <= '0;
            t     <= '0;
            for (int i = 0; i < 16; i++) window[i] <= '0;
        end else if (run) begin
            // A run pulse wins over everything, including a LOAD on the same edge.
            delay <= DELAY_W'(delay0);
        end else begin
            case (state)
                S_DELAY: begin
                    if (delay != '0) delay <= delay - 1'b1;
                end
                S_LOAD: begin
                    for (int i = 0; i < 16; i++) window[i] <= in_w[i];
                    t <= '0;
                end
                S_STREAM: begin
                    for (int i = 0; i < 15; i++) window[i] <= window[i+1];
                    window[15] <= w_next;
                    if (t != 6'(ROUNDS - 1)) t <= t + 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign out0  = window[0];
    assign valid = (state == S_STREAM);
    assign done  = (state == S_DONE);

`ifdef SHA_KROM_EN
    logic [31:0] k_rom;

    sha256_krom u_krom (
        .addr (t),
        .k    (k_rom)
    );

    assign out1 = (state == S_STREAM) ? k_rom : '0;
`else
    assign out1 = '0;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: scoreboard of expected schedule words built
// from an independent FIPS 180-4 model, compared against the streamed out0 words.
module tb_sha256_msg_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic [7:0]  delay0 = 8'd0;
    logic [31:0] in_w [16];
    logic [31:0] out0, out1;
    logic        valid, done;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    int          first_cyc, last_cyc, done_cyc, valid_cnt, gap_cnt, k_bad;
    int          run_cyc, load_cyc;
    logic [31:0] k_first, k_last;
    bit          timeout;
    bit          scramble = 1'b0;
    logic [31:0] blk_a [16];
    logic [31:0] blk_b [16];
    logic [31:0] blk_x [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha256_msg_sched dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .in0    (in_w[0]),
        .in1    (in_w[1]),
        .in2    (in_w[2]),
        .in3    (in_w[3]),
        .in4    (in_w[4]),
        .in5    (in_w[5]),
        .in6    (in_w[6]),
        .in7    (in_w[7]),
        .in8    (in_w[8]),
        .in9    (in_w[9]),
        .in10   (in_w[10]),
        .in11   (in_w[11]),
        .in12   (in_w[12]),
        .in13   (in_w[13]),
        .in14   (in_w[14]),
        .in15   (in_w[15]),
        .delay0 (delay0),
        .out0   (out0),
        .out1   (out1),
        .valid  (valid),
        .done   (done)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule in the textbook W[i-2]/W[i-7]/W[i-15]/W[i-16] form.
    function automatic void push_sched(input logic [31:0] m [16]);
        logic [31:0] w [64];
        for (int i = 0; i < 64; i++) begin
            if (i < 16) w[i] = m[i];
            else w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                      + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
            exp_q.push_back(w[i]);
        end
    endfunction

    task automatic set_inputs(input logic [31:0] m [16]);
        for (int i = 0; i < 16; i++) in_w[i] = m[i];
    endtask

    task automatic rand_block(output logic [31:0] m [16]);
        for (int i = 0; i < 16; i++) m[i] = $urandom();
    endtask

    task automatic pulse_run(input logic [7:0] d);
        @(negedge clk);
        delay0 = d;
        run    = 1'b1;
        @(posedge clk);
        #1;
        run_cyc = cyc;
        run     = 1'b0;
    endtask

    // Observes outputs once per cycle until done rises or the budget expires.
    task automatic capture(input int max_cyc);
        got_q.delete();
        first_cyc = -1; last_cyc = -1; done_cyc = -1;
        valid_cnt = 0;  gap_cnt = 0;   k_bad = 0;
        k_first = '0;   k_last = '0;   timeout = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            if (valid) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    k_first   = out1;
                end else if (last_cyc != cyc - 1) begin
                    gap_cnt++;
                end
                last_cyc = cyc;
                k_last   = out1;
                valid_cnt++;
                got_q.push_back(out0);
            end else if (out1 !== 32'h0) begin
                k_bad++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (scramble) begin
                if (cyc == load_cyc) set_inputs(blk_x);
                else for (int i = 0; i < 16; i++) in_w[i] = $urandom();
            end
        end
        if (done_cyc < 0) timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) in_w[i] = $urandom();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            run = n[0];
            checks++;
            if ({out0, out1, valid, done} !== 66'h0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d: out0=%h out1=%h valid=%b done=%b, required all zero",
                         cyc, out0, out1, valid, done);
            end
        end
        @(negedge clk);
        run = 1'b0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({out0, valid, done} !== 34'h0) begin
            errors++;
            $display("FAIL reset_idle: out0=%h valid=%b done=%b, required idle zeros", out0, valid, done);
        end
    endtask

    task automatic test_abc();
        logic [31:0] e, g;
        for (int i = 0; i < 16; i++) blk_a[i] = 32'h0;
        blk_a[0]  = 32'h61626380;
        blk_a[15] = 32'h00000018;
        exp_q.delete();
        push_sched(blk_a);
        set_inputs(blk_a);
        pulse_run(8'd0);
        capture(120);
        checks++;
        if (timeout) begin errors++; $display("FAIL abc_timeout: done never rose"); end
        checks++;
        if (first_cyc !== run_cyc + 2) begin
            errors++; $display("FAIL abc_first: W_0 at cycle %0d, required %0d", first_cyc, run_cyc + 2);
        end
        checks++;
        if (valid_cnt !== 64 || gap_cnt !== 0) begin
            errors++; $display("FAIL abc_valid_len: %0d valid cycles (%0d gaps), required 64 (0)", valid_cnt, gap_cnt);
        end
        checks++;
        if (done_cyc !== last_cyc + 1) begin
            errors++; $display("FAIL abc_done: done at %0d, required %0d", done_cyc, last_cyc + 1);
        end
        if (got_q.size() >= 18) begin
            checks++;
            if (got_q[0] !== 32'h61626380 || got_q[15] !== 32'h00000018 ||
                got_q[16] !== 32'h61626380 || got_q[17] !== 32'h000F0000) begin
                errors++;
                $display("FAIL abc_known_words: W0=%h W15=%h W16=%h W17=%h, required 61626380 00000018 61626380 000f0000",
                         got_q[0], got_q[15], got_q[16], got_q[17]);
            end
        end
        for (int i = 0; i < 64; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
            g = (got_q.size() > 0) ? got_q.pop_front() : 32'hx;
            checks++;
            if (g !== e) begin errors++; $display("FAIL abc_W%0d: got %h, required %h", i, g, e); end
        end
`ifdef SHA_KROM_EN
        checks++;
        if (k_first !== 32'h428a2f98 || k_last !== 32'hc67178f2) begin
            errors++; $display("FAIL abc_k: K_0=%h K_63=%h, required 428a2f98 c67178f2", k_first, k_last);
        end
`else
        checks++;
        if (k_first !== 32'h0 || k_last !== 32'h0) begin
            errors++; $display("FAIL abc_k_off: out1 first=%h last=%h, required 0", k_first, k_last);
        end
`endif
        checks++;
        if (k_bad !== 0) begin errors++; $display("FAIL abc_k_idle: out1 nonzero on %0d idle cycles, required 0", k_bad); end
    endtask

    task automatic test_delay(input logic [7:0] d);
        logic [31:0] e, g;
        rand_block(blk_a);
        exp_q.delete();
        push_sched(blk_a);
        set_inputs(blk_a);
        pulse_run(d);
        capture(int'(d) + 120);
        checks++;
        if (timeout) begin errors++; $display("FAIL delay%0d_timeout: done never rose", d); end
        checks++;
        if (first_cyc !== run_cyc + 2 + int'(d) || last_cyc !== run_cyc + 65 + int'(d) ||
            done_cyc !== run_cyc + 66 + int'(d)) begin
            errors++;
            $display("FAIL delay%0d_timing: first/last/done=%0d/%0d/%0d, required %0d/%0d/%0d", d,
                     first_cyc - run_cyc, last_cyc - run_cyc, done_cyc - run_cyc, 2 + d, 65 + d, 66 + d);
        end
        for (int i = 0; i < 64; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
            g = (got_q.size() > 0) ? got_q.pop_front() : 32'hx;
            checks++;
            if (g !== e) begin errors++; $display("FAIL delay%0d_W%0d: got %h, required %h", d, i, g, e); end
        end
    endtask

    task automatic test_input_sampling();
        logic [31:0] e, g;
        rand_block(blk_x);
        exp_q.delete();
        push_sched(blk_x);
        for (int i = 0; i < 16; i++) in_w[i] = $urandom();
        scramble = 1'b1;
        pulse_run(8'd2);
        load_cyc = run_cyc + 3;
        capture(120);
        scramble = 1'b0;
        checks++;
        if (timeout || valid_cnt !== 64) begin
            errors++; $display("FAIL sample_len: %0d words, timeout=%b, required 64 and 0", valid_cnt, timeout);
        end
        for (int i = 0; i < 64; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
            g = (got_q.size() > 0) ? got_q.pop_front() : 32'hx;
            checks++;
            if (g !== e) begin errors++; $display("FAIL sample_W%0d: got %h, required %h", i, g, e); end
        end
    endtask

    task automatic test_restart();
        logic [31:0] e, g;
        int idx;
        rand_block(blk_a);
        rand_block(blk_b);
        exp_q.delete();
        push_sched(blk_a);
        set_inputs(blk_a);
        pulse_run(8'd0);
        idx = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (valid) begin
                e = exp_q.pop_front();
                checks++;
                if (out0 !== e) begin errors++; $display("FAIL restart_A_W%0d: got %h, required %h", idx, out0, e); end
                idx++;
                if (idx == 21) begin
                    set_inputs(blk_b);
                    delay0 = 8'd0;
                    run    = 1'b1;
                    @(posedge clk);
                    #1;
                    run_cyc = cyc;
                    run     = 1'b0;
                    break;
                end
            end
        end
        checks++;
        if (idx !== 21) begin errors++; $display("FAIL restart_reach: saw %0d words, required 21", idx); end
        exp_q.delete();
        push_sched(blk_b);
        capture(120);
        checks++;
        if (first_cyc !== run_cyc + 2 || valid_cnt !== 64 || timeout) begin
            errors++;
            $display("FAIL restart_B_timing: first=+%0d words=%0d timeout=%b, required +2 64 0",
                     first_cyc - run_cyc, valid_cnt, timeout);
        end
        for (int i = 0; i < 64; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
            g = (got_q.size() > 0) ? got_q.pop_front() : 32'hx;
            checks++;
            if (g !== e) begin errors++; $display("FAIL restart_B_W%0d: got %h, required %h", i, g, e); end
        end
    endtask

    task automatic test_run_on_load();
        logic [31:0] e, g;
        rand_block(blk_a);
        rand_block(blk_b);
        set_inputs(blk_a);
        pulse_run(8'd0);
        @(negedge clk);
        @(negedge clk);
        set_inputs(blk_b);
        delay0 = 8'd2;
        run    = 1'b1;
        @(posedge clk);
        #1;
        run_cyc = cyc;
        run     = 1'b0;
        exp_q.delete();
        push_sched(blk_b);
        capture(120);
        checks++;
        if (first_cyc !== run_cyc + 4 || valid_cnt !== 64 || timeout) begin
            errors++;
            $display("FAIL run_on_load_timing: first=+%0d words=%0d timeout=%b, required +4 64 0",
                     first_cyc - run_cyc, valid_cnt, timeout);
        end
        for (int i = 0; i < 64; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
            g = (got_q.size() > 0) ? got_q.pop_front() : 32'hx;
            checks++;
            if (g !== e) begin errors++; $display("FAIL run_on_load_W%0d: got %h, required %h", i, g, e); end
        end
    endtask

    task automatic test_async_reset();
        rand_block(blk_a);
        set_inputs(blk_a);
        pulse_run(8'd0);
        repeat (6) @(negedge clk);
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL areset_pre: valid=%b, required 1", valid); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({out0, out1, valid, done} !== 66'h0) begin
            errors++;
            $display("FAIL areset_now: out0=%h out1=%h valid=%b done=%b, required all zero", out0, out1, valid, done);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({valid, done} !== 2'b00) begin
            errors++; $display("FAIL areset_idle: valid=%b done=%b, required 0 0", valid, done);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_abc();
        test_delay(8'd3);
        test_delay(8'd255);
        test_input_sampling();
        test_restart();
        test_run_on_load();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- SHA-256 message-schedule unit: the Versat stage directly upstream of the SHA-256 compression-round unit.
- Takes one 512-bit block as 16 parallel 32-bit words and streams W_0..W_63, one word per cycle, on out0.
- out0 feeds the round unit's w input; out1 carries the round constant K_t that feeds its k input.
- Start uses the same run/delay configuration scheme as the round unit, so both units can be aligned by delay values.

Parameters:
- DELAY_W, 10: width of the internal delay counter; delay0 is zero-extended into it.
- DATA_W, 32: datapath word width; only 32 is supported.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- run  in  1  single-cycle start pulse
- in0..in15  in  DATA_W each  block words M_0..M_15, big-endian word order (in0 = M_0)
- delay0  in  8  cycles to wait after run before sampling the block
- out0  out  DATA_W  current schedule word W_t
- out1  out  DATA_W  round constant K_t, gated by SHA_KROM_EN
- valid  out  1  out0/out1 hold W_t/K_t for t in 0..63
- done  out  1  high from the cycle after W_63 until the next run

Behaviour:
- Reset (rst=0, async): state=IDLE; window[0..15], t, delay counter, out0, out1, valid and done all 0.
- States: IDLE, DELAY, LOAD, STREAM, DONE.
- Priority: run > state logic. run in any state: delay <= delay0, done <= 0, valid <= 0, state <= DELAY. This restarts a block mid-stream, and partial output is discarded.
- DELAY: if delay != 0, decrement; else state <= LOAD. delay0=0 gives exactly one DELAY cycle.
- LOAD (1 cycle): window[i] <= in_i for i=0..15; t <= 0; state <= STREAM. Inputs are sampled only on this edge.
- STREAM (64 cycles):
  - out0 = window[0]; valid = 1; out1 = K[t].
  - Each cycle: window[i] <= window[i+1] for i=0..14; window[15] <= Wn.
  - Wn = s1(window[14]) + window[9] + s0(window[1]) + window[0], mod 2^32.
  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3; s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - t increments each cycle. When t==63: state <= DONE, t holds.
- DONE: valid=0, done=1. out0 holds the last window[0] and carries no meaning. Stays until the next run.
- Latency: run at cycle c → LOAD at c+1+delay0 → W_0 valid at c+2+delay0 → W_63 at c+65+delay0 → done at c+66+delay0.
- Alignment: the round unit consumes W_0 on its first compute cycle, i.e. two cycles after its own delay expires. The integrator sets this unit's delay0 = round-unit delay0 (run pulses aligned) so W_0 lands on that cycle.
- The t counter never wraps past 63. The window does not shift outside STREAM.

Optional Feature:
- Macro SHA_KROM_EN.
- Defined: internal 64x32 constant ROM (K_0=0x428a2f98 ... K_63=0xc67178f2); out1 = K[t] during STREAM, 0 otherwise.
- Undefined: no ROM; out1 is tied to 0 and K must be supplied externally.

Decomposition:
- Shared package sha256_pkg: the 64 K constants, the s0/s1 functions, and localparams for the state encoding and ROUNDS=64.
- The same package also serves the round unit's Sigma/Ch/Maj definitions.
- One sub-module, sha256_krom: combinational 6-bit address → 32-bit constant, instantiated only under SHA_KROM_EN.

Test Plan:
- Reset: hold rst=0 with run toggling → out0=0, out1=0, valid=0, done=0, state IDLE. Release; nothing happens until run.
- "abc" block: in0=0x61626380, in1..in14=0, in15=0x00000018, delay0=0.
  - valid high for exactly 64 cycles.
  - W_0=0x61626380, W_15=0x00000018, W_16=0x61626380, W_17=0x000F0000.
  - W_0..W_63 match the FIPS 180-4 software model.
  - done rises the cycle after W_63.
- Delay timing: delay0=3, run at cycle 10 → W_0 valid at cycle 15, last valid at 78, done at 79. Repeat with delay0=255.
- Input sampling: change in0..in15 every cycle except the LOAD edge → output unaffected. Changing inputs during STREAM has no effect.
- Mid-stream restart: pulse run at t=20 with a new block, delay0=0 → valid drops next cycle, then 64 fresh words from the new block, and no leftover words. Also cover run asserted the same cycle as LOAD.
- Constants (SHA_KROM_EN defined): out1=0x428a2f98 with W_0 and 0xc67178f2 with W_63. Undefined build: out1 stays 0 throughout.
